// File: rtl/pio_bus_master.sv
// pio_bus_master: Avalon-MM initiator for single-register PIO slaves, fed from a small command FIFO.
// Optional readback verification of every write is enabled by defining PIO_MASTER_READBACK_EN.
module pio_bus_master #(
   parameter int ADDR_W       = 2,
   parameter int DATA_W       = 8,
   parameter int FIFO_DEPTH   = 4,
   parameter int READ_LATENCY = 0
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic              cmd_write_i,
   input  logic [ADDR_W-1:0] cmd_address_i,
   input  logic [DATA_W-1:0] cmd_wdata_i,
   output logic              rsp_valid_o,
   output logic [DATA_W-1:0] rsp_rdata_o,
   output logic              busy_o,
   output logic              err_mismatch_o,
   output logic [ADDR_W-1:0] address_o,
   output logic              chipselect_o,
   output logic              write_n_o,
   output logic              read_n_o,
   output logic [DATA_W-1:0] writedata_o,
   input  logic [DATA_W-1:0] readdata_i
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int ENT_W = 1 + ADDR_W + DATA_W;
   localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);
   localparam logic [1:0] LAT_LAST = (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;

   typedef enum logic [1:0] {IDLE, XFER, RWAIT} state_t;

   logic [ENT_W-1:0]  fifo_mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]    count_q, count_d;
   logic              full, empty, push, pop, capture;
   logic              head_write;
   logic [ADDR_W-1:0] head_addr;
   logic [DATA_W-1:0] head_data;

   state_t            state_q;
   logic              cur_write_q;
   logic [1:0]        lat_cnt_q;
   logic              chipselect_q, write_n_q, read_n_q;
   logic [ADDR_W-1:0] address_q;
   logic [DATA_W-1:0] writedata_q;
   logic              rsp_valid_q;
   logic [DATA_W-1:0] rsp_rdata_q;

   assign full        = (count_q == FULL_COUNT);
   assign empty       = (count_q == '0);
   assign push        = cmd_valid_i && !full;
   assign cmd_ready_o = !full;
   assign {head_write, head_addr, head_data} = fifo_mem_q[rd_ptr_q];

   // Writes chain back-to-back only when no readback has to be slotted in behind them.
`ifdef PIO_MASTER_READBACK_EN
   assign pop = !empty && (state_q == IDLE);
`else
   assign pop = !empty && ((state_q == IDLE) || ((state_q == XFER) && cur_write_q));
`endif

   assign capture = ((state_q == XFER) && !cur_write_q && (READ_LATENCY == 0)) ||
                    ((state_q == RWAIT) && (lat_cnt_q == LAT_LAST));

   always_comb begin
      count_d = count_q;
      if (push && !pop)
         count_d = count_q + 1'b1;
      else if (!push && pop)
         count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            fifo_mem_q[wr_ptr_q] <= {cmd_write_i, cmd_address_i, cmd_wdata_i};
            wr_ptr_q             <= wr_ptr_q + 1'b1;
         end
         if (pop)
            rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

`ifdef PIO_MASTER_READBACK_EN
   logic              is_rb_q, rb_check_q, err_q;
   logic [DATA_W-1:0] rb_wdata_q, rb_data_q;
`endif

   // Bus strobes default to idle every cycle; a pop or readback re-arms them for exactly one cycle.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q      <= IDLE;
         cur_write_q  <= 1'b0;
         lat_cnt_q    <= 2'd0;
         chipselect_q <= 1'b0;
         write_n_q    <= 1'b1;
         read_n_q     <= 1'b1;
         address_q    <= '0;
         writedata_q  <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_rdata_q  <= '0;
`ifdef PIO_MASTER_READBACK_EN
         is_rb_q      <= 1'b0;
         rb_check_q   <= 1'b0;
         err_q        <= 1'b0;
         rb_wdata_q   <= '0;
         rb_data_q    <= '0;
`endif
      end else begin
         chipselect_q <= 1'b0;
         write_n_q    <= 1'b1;
         read_n_q     <= 1'b1;
         address_q    <= '0;
         writedata_q  <= '0;
         rsp_valid_q  <= 1'b0;
`ifdef PIO_MASTER_READBACK_EN
         rb_check_q   <= 1'b0;
         if (rb_check_q && (rb_data_q != rb_wdata_q))
            err_q <= 1'b1;
`endif
         if (pop) begin
            chipselect_q <= 1'b1;
            write_n_q    <= !head_write;
            read_n_q     <= head_write;
            address_q    <= head_addr;
            writedata_q  <= head_write ? head_data : '0;
            cur_write_q  <= head_write;
`ifdef PIO_MASTER_READBACK_EN
            is_rb_q      <= 1'b0;
`endif
         end

         if (capture) begin
`ifdef PIO_MASTER_READBACK_EN
            if (is_rb_q) begin
               rb_data_q  <= readdata_i;
               rb_check_q <= 1'b1;
            end else begin
               rsp_rdata_q <= readdata_i;
               rsp_valid_q <= 1'b1;
            end
`else
            rsp_rdata_q <= readdata_i;
            rsp_valid_q <= 1'b1;
`endif
         end

         case (state_q)
            IDLE: begin
               if (pop)
                  state_q <= XFER;
            end
            XFER: begin
               if (cur_write_q) begin
`ifdef PIO_MASTER_READBACK_EN
                  chipselect_q <= 1'b1;
                  read_n_q     <= 1'b0;
                  address_q    <= address_q;
                  cur_write_q  <= 1'b0;
                  is_rb_q      <= 1'b1;
                  rb_wdata_q   <= writedata_q;
`else
                  if (!pop)
                     state_q <= IDLE;
`endif
               end else if (READ_LATENCY == 0) begin
                  state_q <= IDLE;
               end else begin
                  lat_cnt_q <= 2'd0;
                  state_q   <= RWAIT;
               end
            end
            RWAIT: begin
               if (lat_cnt_q == LAT_LAST)
                  state_q <= IDLE;
               else
                  lat_cnt_q <= lat_cnt_q + 2'd1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef PIO_MASTER_READBACK_EN
   assign err_mismatch_o = err_q;
`else
   assign err_mismatch_o = 1'b0;
`endif

   assign busy_o       = !empty || (state_q != IDLE);
   assign rsp_valid_o  = rsp_valid_q;
   assign rsp_rdata_o  = rsp_rdata_q;
   assign address_o    = address_q;
   assign chipselect_o = chipselect_q;
   assign write_n_o    = write_n_q;
   assign read_n_o     = read_n_q;
   assign writedata_o  = writedata_q;

endmodule

// File: tb/tb_pio_bus_master.sv
// tb_pio_bus_master: directed bench for pio_bus_master with a PIO slave model of read latency 2.
// Define PIO_MASTER_READBACK_EN to exercise the readback-compare build instead of the cycle-exact write tests.
module tb_pio_bus_master;

   localparam int ADDR_W = 2;
   localparam int DATA_W = 8;
   localparam int LAT    = 2;

   logic              clk = 1'b0;
   logic              reset;
   logic              cmdValid, cmdReady, cmdWrite;
   logic [ADDR_W-1:0] cmdAddress;
   logic [DATA_W-1:0] cmdWdata;
   logic              rspValid, busy, errMismatch;
   logic [DATA_W-1:0] rspRdata;
   logic [ADDR_W-1:0] address;
   logic              chipselect, writeN, readN;
   logic [DATA_W-1:0] writedata, readdata;
   logic [DATA_W-1:0] corruptMask;

   int checkCount = 0;
   int errorCount = 0;

   always #5 clk = ~clk;

   pio_bus_master #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(4), .READ_LATENCY(LAT)
   ) dut (
      .clk_i(clk), .reset_i(reset),
      .cmd_valid_i(cmdValid), .cmd_ready_o(cmdReady), .cmd_write_i(cmdWrite),
      .cmd_address_i(cmdAddress), .cmd_wdata_i(cmdWdata),
      .rsp_valid_o(rspValid), .rsp_rdata_o(rspRdata), .busy_o(busy),
      .err_mismatch_o(errMismatch),
      .address_o(address), .chipselect_o(chipselect), .write_n_o(writeN),
      .read_n_o(readN), .writedata_o(writedata), .readdata_i(readdata)
   );

   // PIO slave model: register file, read data valid LAT=2 cycles after the read strobe
   logic [DATA_W-1:0] slaveRegs [4];
   logic [DATA_W-1:0] rdStage1, rdStage2;

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) slaveRegs[i] <= '0;
         rdStage1 <= '0;
         rdStage2 <= '0;
      end else begin
         if (chipselect && !writeN) slaveRegs[address] <= writedata;
         rdStage1 <= slaveRegs[address];
         rdStage2 <= rdStage1;
      end
   end

   assign readdata = rdStage2 ^ corruptMask;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic valid, input logic write,
                                input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
      cmdValid   = valid;
      cmdWrite   = write;
      cmdAddress = addr;
      cmdWdata   = data;
   endtask

   task automatic waitRsp(output logic [DATA_W-1:0] data, output logic seen);
      seen = 1'b0;
      data = '0;
      for (int i = 0; i < 30 && !seen; i++) begin
         tick();
         if (rspValid) begin
            seen = 1'b1;
            data = rspRdata;
         end
      end
   endtask

   task automatic waitIdle();
      for (int i = 0; i < 30 && busy; i++) tick();
      checkOutput("idle_wait", 32'(busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [DATA_W-1:0] rdData;
      logic              seen;

      reset       = 1'b1;
      corruptMask = '0;
      applyStimulus(1'b0, 1'b0, '0, '0);
      tick();
      tick();
      reset = 1'b0;

      // Reset state
      checkOutput("rst_cmd_ready", 32'(cmdReady), 32'd1);
      checkOutput("rst_rsp_valid", 32'(rspValid), 32'd0);
      checkOutput("rst_rsp_rdata", 32'(rspRdata), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_err", 32'(errMismatch), 32'd0);
      checkOutput("rst_address", 32'(address), 32'd0);
      checkOutput("rst_cs", 32'(chipselect), 32'd0);
      checkOutput("rst_write_n", 32'(writeN), 32'd1);
      checkOutput("rst_read_n", 32'(readN), 32'd1);
      checkOutput("rst_writedata", 32'(writedata), 32'd0);

      // Test 1: single write to address 0
      applyStimulus(1'b1, 1'b1, 2'd0, 8'hA5);
      tick();
      applyStimulus(1'b0, 1'b0, '0, '0);
      checkOutput("t1_cs_before", 32'(chipselect), 32'd0);
      checkOutput("t1_busy", 32'(busy), 32'd1);
      tick();
      checkOutput("t1_cs", 32'(chipselect), 32'd1);
      checkOutput("t1_write_n", 32'(writeN), 32'd0);
      checkOutput("t1_read_n", 32'(readN), 32'd1);
      checkOutput("t1_addr", 32'(address), 32'd0);
      checkOutput("t1_wdata", 32'(writedata), 32'hA5);
      tick();
      checkOutput("t1_cs_after", 32'(chipselect), 32'd0);
      checkOutput("t1_write_n_after", 32'(writeN), 32'd1);
      checkOutput("t1_wdata_after", 32'(writedata), 32'd0);
`ifndef PIO_MASTER_READBACK_EN
      checkOutput("t1_busy_after", 32'(busy), 32'd0);
`endif
      waitIdle();
      tick();

`ifndef PIO_MASTER_READBACK_EN
      // Test 3: write 0x3C to addr 2, then read it back with latency 2
      applyStimulus(1'b1, 1'b1, 2'd2, 8'h3C);
      tick();
      applyStimulus(1'b1, 1'b0, 2'd2, 8'h00);
      tick();
      applyStimulus(1'b0, 1'b0, '0, '0);
      checkOutput("t3_wr_strobe", 32'({chipselect, writeN, readN}), 32'b101);
      checkOutput("t3_wr_data", 32'(writedata), 32'h3C);
      tick();
      checkOutput("t3_rd_strobe", 32'({chipselect, writeN, readN}), 32'b110);
      checkOutput("t3_rd_addr", 32'(address), 32'd2);
      tick();
      checkOutput("t3_rwait1_bus", 32'({chipselect, writeN, readN}), 32'b011);
      checkOutput("t3_rwait1_rsp", 32'(rspValid), 32'd0);
      tick();
      checkOutput("t3_rwait2_rsp", 32'(rspValid), 32'd0);
      tick();
      checkOutput("t3_rsp_valid", 32'(rspValid), 32'd1);
      checkOutput("t3_rsp_rdata", 32'(rspRdata), 32'h3C);
      checkOutput("t3_idle_cs", 32'(chipselect), 32'd0);
      tick();
      checkOutput("t3_rsp_pulse", 32'(rspValid), 32'd0);
      checkOutput("t3_rsp_hold", 32'(rspRdata), 32'h3C);
      checkOutput("t3_busy", 32'(busy), 32'd0);
      tick();

      // Test 2: read keeps the FSM busy while 4 writes fill the FIFO
      applyStimulus(1'b1, 1'b0, 2'd0, 8'h00);
      tick();
      applyStimulus(1'b1, 1'b1, 2'd0, 8'h01);
      tick();
      checkOutput("t2_rd_strobe", 32'({chipselect, readN}), 32'b10);
      applyStimulus(1'b1, 1'b1, 2'd1, 8'h02);
      tick();
      applyStimulus(1'b1, 1'b1, 2'd2, 8'h03);
      tick();
      checkOutput("t2_ready_3", 32'(cmdReady), 32'd1);
      applyStimulus(1'b1, 1'b1, 2'd3, 8'h04);
      tick();
      applyStimulus(1'b0, 1'b0, '0, '0);
      checkOutput("t2_ready_full", 32'(cmdReady), 32'd0);
      checkOutput("t2_rsp_valid", 32'(rspValid), 32'd1);
      checkOutput("t2_rsp_rdata", 32'(rspRdata), 32'hA5);
      for (int i = 0; i < 4; i++) begin
         tick();
         if (i == 0) checkOutput("t2_ready_rise", 32'(cmdReady), 32'd1);
         checkOutput($sformatf("t2_strobe%0d", i), 32'({chipselect, writeN, readN}), 32'b101);
         checkOutput($sformatf("t2_addr%0d", i), 32'(address), 32'(i));
         checkOutput($sformatf("t2_wdata%0d", i), 32'(writedata), 32'(i + 1));
      end
      tick();
      checkOutput("t2_cs_end", 32'(chipselect), 32'd0);
      checkOutput("t2_busy_end", 32'(busy), 32'd0);
      tick();
`endif

      // Test 4: write 0x55 then read same address through slave model
      applyStimulus(1'b1, 1'b1, 2'd1, 8'h55);
      tick();
      applyStimulus(1'b1, 1'b0, 2'd1, 8'h00);
      tick();
      applyStimulus(1'b0, 1'b0, '0, '0);
      waitRsp(rdData, seen);
      checkOutput("t4_rsp_seen", 32'(seen), 32'd1);
      checkOutput("t4_rsp_rdata", 32'(rdData), 32'h55);
      waitIdle();
      checkOutput("t4_err", 32'(errMismatch), 32'd0);
      tick();

      // Test 5: reset during RWAIT with two writes queued
      applyStimulus(1'b1, 1'b0, 2'd0, 8'h00);
      tick();
      applyStimulus(1'b1, 1'b1, 2'd2, 8'h77);
      tick();
      checkOutput("t5_rd_strobe", 32'({chipselect, readN}), 32'b10);
      applyStimulus(1'b1, 1'b1, 2'd3, 8'h88);
      tick();
      applyStimulus(1'b0, 1'b0, '0, '0);
      checkOutput("t5_rwait_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkOutput("t5_cs", 32'(chipselect), 32'd0);
      checkOutput("t5_read_n", 32'(readN), 32'd1);
      checkOutput("t5_ready", 32'(cmdReady), 32'd1);
      checkOutput("t5_busy", 32'(busy), 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         checkOutput($sformatf("t5_no_rsp%0d", i), 32'(rspValid), 32'd0);
         checkOutput($sformatf("t5_no_cs%0d", i), 32'(chipselect), 32'd0);
      end

`ifdef PIO_MASTER_READBACK_EN
      // Test 6: slave corrupts bit 0, readback compare must flag it
      corruptMask = 8'h01;
      applyStimulus(1'b1, 1'b1, 2'd3, 8'hF0);
      tick();
      applyStimulus(1'b0, 1'b0, '0, '0);
      tick();
      checkOutput("t6_wr_strobe", 32'({chipselect, writeN, readN}), 32'b101);
      tick();
      checkOutput("t6_rb_strobe", 32'({chipselect, writeN, readN}), 32'b110);
      checkOutput("t6_rb_addr", 32'(address), 32'd3);
      for (int i = 1; i <= LAT + 2; i++) begin
         tick();
         checkOutput($sformatf("t6_no_rsp%0d", i), 32'(rspValid), 32'd0);
         checkOutput($sformatf("t6_err%0d", i), 32'(errMismatch), (i == LAT + 2) ? 32'd1 : 32'd0);
      end
      corruptMask = 8'h00;
      for (int i = 0; i < 4; i++) tick();
      checkOutput("t6_err_sticky", 32'(errMismatch), 32'd1);
      checkOutput("t6_busy", 32'(busy), 32'd0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkOutput("t6_err_cleared", 32'(errMismatch), 32'd0);
`endif

      tick();
      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
